// File: rtl/memsys_arb.sv
// Shared single-port word RAM serving an instruction-fetch port and a data port.
// Round-robin arbitration, programmable wait states, one-cycle ready pulses.
module memsys_arb #(
    parameter int ADDR_W = 6,
    parameter int WAIT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT > 0) ? WAIT - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                sel_d_q;
    logic                we_q;
    logic [3:0]          be_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         wdata_q;
    logic                last_d_q;
    logic [31:0]         i_rdata_q, d_rdata_q;
    logic                i_ready_q, d_ready_q;

    logic [31:0]         mem [DEPTH];

    logic                in_idle, grant, grant_d, enter_resp;
    logic                acc_d, acc_we;
    logic [3:0]          acc_be;
    logic [31:0]         acc_wdata, mem_word, merged;
    logic [ADDR_W-1:0]   acc_idx;
    logic                unused_addr_bits;

    // Address bits outside the word index alias onto the same RAM word.
    assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    always_comb begin
        in_idle    = (state_q == ST_IDLE);
        grant      = i_req | d_req;
        grant_d    = d_req & (~i_req | ~last_d_q);
        // In IDLE the access fields come straight from the ports so WAIT=0 needs no extra cycle.
        acc_d      = in_idle ? grant_d : sel_d_q;
        acc_we     = in_idle ? (grant_d & d_we) : we_q;
        acc_be     = in_idle ? d_be : be_q;
        acc_wdata  = in_idle ? d_wdata : wdata_q;
        acc_idx    = in_idle ? (grant_d ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2]) : idx_q;
        enter_resp = in_idle ? (grant && (WAIT == 0))
                             : ((state_q == ST_WAIT) && (cnt_q == '0));
        mem_word   = mem[acc_idx];
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[8*gi +: 8] = (acc_we && acc_be[gi]) ? acc_wdata[8*gi +: 8]
                                                              : mem_word[8*gi +: 8];
        end
    endgenerate

    // RAM contents survive reset; a reset in WAIT suppresses the pending commit.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && acc_we) begin
            mem[acc_idx] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sel_d_q   <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            last_d_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            if (enter_resp) begin
                if (acc_d) begin
                    d_rdata_q <= merged;
                    d_ready_q <= 1'b1;
                end else begin
                    i_rdata_q <= merged;
                    i_ready_q <= 1'b1;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        sel_d_q  <= grant_d;
                        last_d_q <= grant_d;
                        we_q     <= grant_d & d_we;
                        be_q     <= d_be;
                        wdata_q  <= d_wdata;
                        idx_q    <= acc_idx;
                        cnt_q    <= CNT_LOAD;
                        state_q  <= (WAIT == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ready = i_ready_q;
    assign d_ready = d_ready_q;
    assign busy    = (state_q != ST_IDLE);
endmodule

// File: doc/memsys_arb.md
MEMSYS_ARB -- requirements
Module: memsys_arb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, meaning word-address bits (memory depth 2^ADDR_W words).
REQ-002 The block SHALL have parameter WAIT, default 1, range 0..15, meaning access wait states inserted before response.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port i_req  input  1  instruction-fetch request.
REQ-006 The block SHALL have port i_addr  input  32  instruction byte address.
REQ-007 The block SHALL have port i_rdata  output  32  fetched instruction word.
REQ-008 The block SHALL have port i_ready  output  1  one-cycle fetch-complete pulse.
REQ-009 The block SHALL have port d_req  input  1  data-access request.
REQ-010 The block SHALL have port d_we  input  1  1 = write, 0 = read.
REQ-011 The block SHALL have port d_be  input  4  byte enables; bit k selects bits 8k+7:8k.
REQ-012 The block SHALL have port d_addr  input  32  data byte address.
REQ-013 The block SHALL have port d_wdata  input  32  write data.
REQ-014 The block SHALL have port d_rdata  output  32  read data.
REQ-015 The block SHALL have port d_ready  output  1  one-cycle data-complete pulse.
REQ-016 The block SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-017 The block SHALL hold one single-port RAM of 2^ADDR_W x 32 shared by both ports; word index = addr[ADDR_W+1:2]; addr[1:0] and addr[31:ADDR_W+2] ignored (aliasing/wrap).
REQ-018 The FSM SHALL have states IDLE, WAIT, RESP; requests sampled only in IDLE.
REQ-019 In IDLE with exactly one req high, that port SHALL be granted; address, d_we, d_be, d_wdata latched at the grant edge.
REQ-020 In IDLE with both req high, the port not granted most recently SHALL be granted (round-robin); last-grant flag updates on every grant.
REQ-021 IDLE SHALL go to WAIT on grant when WAIT>0, directly to RESP when WAIT=0, and stay IDLE with no req.
REQ-022 The grant-to-ready latency SHALL be exactly WAIT+1 cycles: request accepted in IDLE cycle N -> ready high in cycle N+1+WAIT.
REQ-023 Wait-state counter SHALL be $clog2(WAIT+1) bits (min 1), loaded at grant, decremented in WAIT; WAIT->RESP when count exhausted.
REQ-024 Reads SHALL capture the addressed word into the granted port's rdata at the edge entering RESP.
REQ-025 Writes SHALL commit at the edge entering RESP, updating only bytes with d_be=1; d_rdata SHALL then show the merged word.
REQ-026 d_be=0000 write SHALL complete normally with memory unchanged.
REQ-027 RESP SHALL last exactly one cycle with the granted port's ready=1 and the other ready=0, then return to IDLE.
REQ-028 i_rdata/d_rdata SHALL hold value until that port's next completion.
REQ-029 Requester SHALL hold req and request fields until ready; req dropped after grant SHALL NOT abort the transaction.
REQ-030 Back-to-back: the earliest next grant SHALL be in the IDLE cycle after RESP (max throughput one access per WAIT+2 cycles).
REQ-031 i_ready and d_ready SHALL never be high in the same cycle.

Reset
REQ-032 Reset SHALL force state IDLE, counter 0, i_ready=0, d_ready=0, busy=0, i_rdata=0, d_rdata=0, last-grant=instruction (data wins first tie).
REQ-033 Reset SHALL take priority over all other inputs in the same cycle.
REQ-034 Reset in WAIT SHALL abort: no memory write, no ready pulse; RAM contents are never cleared by reset.

Verification
REQ-035 WAIT=2: d_req, d_we=1, d_be=1111, d_addr=0x10, d_wdata=0xDEADBEEF accepted cycle N -> d_ready=1 only in N+3; later read 0x10 returns 0xDEADBEEF.
REQ-036 Then write d_be=0010, d_wdata=0x0000AA00 to 0x10 -> d_rdata=0xDEADAAEF; read of 0x10 returns 0xDEADAAEF.
REQ-037 After reset, i_req and d_req held high continuously -> grants alternate data, instr, data, instr; ready pulses never overlap.
REQ-038 ADDR_W=6: write 0x12345678 to d_addr=0x100 -> i_req at i_addr=0x000 returns i_rdata=0x12345678.
REQ-039 WAIT=3: reset asserted in second WAIT cycle of write 0xCAFEF00D to 0x20 -> no ready pulse, busy=0 next cycle, read 0x20 returns prior value.
REQ-040 WAIT=0: read accepted cycle N -> d_ready in N+1 only, busy high in N+1 only.
